seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, a request to begin a division, sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH bits, dividend, captured on start acceptance.
REQ-006 SHALL have port B, input, WIDTH bits, divisor, captured on start acceptance.
REQ-007 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit, a single-cycle pulse when Q/R become valid.
REQ-009 SHALL have port Q, output, WIDTH bits, quotient.
REQ-010 SHALL have port R, output, WIDTH bits, remainder.
REQ-011 SHALL have port div_zero, output, 1 bit, set with done when the captured B was 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 IDLE: start=1 SHALL capture A and B; B!=0 -> RUN with iteration counter 0; B==0 -> DONE directly.
REQ-014 RUN SHALL perform one restoring shift-subtract step per cycle on a WIDTH+1-bit partial remainder: shift in the next dividend MSB, subtract B, set the quotient bit to 1 if the result is non-negative, otherwise restore and set it to 0.
REQ-015 RUN SHALL last exactly WIDTH cycles, then go to DONE; the counter SHALL be $clog2(WIDTH+1) bits.
REQ-016 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-017 Latency: start accepted at edge N -> done=1 in the cycle after edge N+WIDTH+1 (B!=0), or after edge N+1 (B==0).
REQ-018 Q, R and div_zero SHALL update only on the edge entering DONE, and SHALL hold until the next DONE or reset.
REQ-019 For B==0: Q=all ones, R=A, div_zero=1. Otherwise div_zero=0, A = Q*B + R, and R < B.
REQ-020 start while busy=1, including in DONE, SHALL be ignored; A and B changes during RUN SHALL have no effect.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE and set busy=0, done=0, Q=0, R=0, div_zero=0, and the counter to 0, regardless of state.
REQ-022 Reset SHALL abort an in-progress division; no done pulse SHALL follow.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 Macro DIV_SIGNED_EN defined: SHALL add input port sgn (1 bit, captured with A and B).
- sgn=1 treats A and B as two's complement; the quotient truncates toward zero; R takes the sign of A.
- Magnitude conversion happens at capture and sign fix-up on entry to DONE, so latency is unchanged.
- Most-negative/-1 SHALL give Q=most-negative and R=0.
- B==0 behaves per REQ-019.
REQ-025 Macro DIV_SIGNED_EN undefined: SHALL have no sgn port, and all operands SHALL be unsigned.

Verification (WIDTH=8)
REQ-026 A=100, B=10, one-cycle start -> done exactly 9 cycles after the accept edge; Q=10, R=0, div_zero=0.
REQ-027 Back-to-back A=255/B=5 then A=16/B=3, restarted in IDLE -> Q=51, R=0, then Q=5, R=1; Q/R stable between the two done pulses.
REQ-028 A=7, B=0 -> done 1 cycle after accept; Q=0xFF, R=7, div_zero=1.
REQ-029 A=200, B=40 started, then start held high with A=90, B=9 during RUN -> a single done with Q=5, R=0; next division begins only after return to IDLE.
REQ-030 rst pulsed at RUN cycle 4 -> busy=0 next cycle, Q=R=0, no done pulse; a fresh A=70, B=10 then gives Q=7, R=0.
REQ-031 With DIV_SIGNED_EN and sgn=1: A=0xF9 (-7), B=2 -> Q=0xFD (-3), R=0xFF (-1); A=0x80, B=0xFF -> Q=0x80, R=0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider producing one quotient bit per clock.
// Define DIV_SIGNED_EN to add the sgn input for two's-complement operands.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef DIV_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_div_zero;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_last;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;

`ifdef DIV_SIGNED_EN
    assign w_sgn = sgn;
`else
    assign w_sgn = 1'b0;
`endif

    // Operands are reduced to magnitudes at capture; signs are re-applied on entry to DONE.
    assign w_a_neg  = w_sgn & A[WIDTH-1];
    assign w_b_neg  = w_sgn & B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~A + WIDTH'(1)) : A;
    assign w_b_mag  = w_b_neg ? (~B + WIDTH'(1)) : B;
    assign w_b_zero = (B == '0);

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // One restoring step: shift in the next dividend MSB, trial-subtract, keep or restore.
    assign w_shifted  = {r_rem, r_dividend[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, r_divisor};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

    assign w_q_mag   = {r_dividend[WIDTH-2:0], w_qbit};
    assign w_q_final = r_neg_q ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
    assign w_r_final = r_neg_r ? (~w_rem_next + WIDTH'(1)) : w_rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = w_b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_div_zero <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_divisor <= w_b_mag;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        if (w_b_zero) begin
                            r_dividend <= A;
                            r_q        <= '1;
                            r_r        <= A;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_dividend <= w_a_mag;
                        end
                    end
                end
                RUN: begin
                    r_dividend <= w_q_mag;
                    r_rem      <= w_rem_next;
                    r_cnt      <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_q        <= w_q_final;
                        r_r        <= w_r_final;
                        r_div_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Q        = r_q;
    assign R        = r_r;
    assign div_zero = r_div_zero;

endmodule
